sync_fifo_wr_arbiter: RTL and testbench



---
 rtl/sync_fifo_arb_pkg.sv | 26 ++
 rtl/sync_fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/sync_fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_arb_pkg.sv
// Shared types, helpers and default sizing for the FIFO write arbiter and its schedulers.
package sync_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int DEPTH_WIDTH_DEF = 8;
  localparam int DEPTH           = 2 ** DEPTH_WIDTH_DEF;
  localparam int OCC_W           = DEPTH_WIDTH_DEF + 1;

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, rr_ptr itself last.
module rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Wrap-around candidates (0..rr_ptr) first, then the preferred ones above rr_ptr override them.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j <= int'(rr_ptr))) begin
        found = 1'b1;
        index = IDX_W'(j);
      end
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(rr_ptr))) begin
        found = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one single-clock FIFO write port.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF,
  parameter int MAX_PKT_LEN = 16,
  localparam int IDX_W      = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic                        wr_clk,
  input  logic                        wr_rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  input  logic                        fifo_rd_en,
  input  logic                        fifo_rd_empty,
  input  logic                        fifo_wr_full,
  output logic [DEPTH_WIDTH:0]        occupancy,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        err_oversize,
  output logic                        err_overflow
);

  localparam int OCC_N = DEPTH_WIDTH + 1;
  localparam logic [OCC_N-1:0] DEPTH_OCC = OCC_N'(2 ** DEPTH_WIDTH);
  localparam logic [OCC_N-1:0] MAX_OCC   = OCC_N'(MAX_PKT_LEN);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               start_grant;
  logic [OCC_N-1:0]   free_cnt;
  logic [OCC_N-1:0]   beat_cnt;
  logic               start_ok;
  logic               beat_ok;
  logic               accept;
  logic               accept_last;
  logic               rd_dec;

  assign free_cnt    = DEPTH_OCC - occupancy;
  assign start_ok    = free_cnt >= MAX_OCC;
  assign beat_ok     = occupancy < DEPTH_OCC;
  assign accept      = (state == BUSY) && beat_ok && req_valid[grant_id];
  assign accept_last = accept && req_last[grant_id];
  assign rd_dec      = fifo_rd_en && !fifo_rd_empty && (occupancy != '0);
  assign busy        = (state == BUSY);

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  // State register for the grant FSM.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and ready: ready depends only on registered grant and occupancy, never on req_valid.
  always_comb begin
    next_state  = state;
    req_ready   = '0;
    start_grant = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok && pick_found) begin
          start_grant = 1'b1;
          next_state  = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_id] = beat_ok;
        if (accept_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant and round-robin pointer; the pointer moves only when a packet completes.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (start_grant) grant_id <= pick_idx;
      if (accept_last) rr_ptr <= grant_id;
    end
  end

  // Per-packet beat count and sticky oversize flag on a beat that reaches the limit without last.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      beat_cnt     <= '0;
      err_oversize <= 1'b0;
    end else begin
      if (accept_last) beat_cnt <= '0;
      else if (accept && (beat_cnt != MAX_OCC)) beat_cnt <= beat_cnt + 1'b1;
      if (accept && !req_last[grant_id] && (beat_cnt >= MAX_OCC - 1'b1)) err_oversize <= 1'b1;
    end
  end

  // Registered write port, one cycle after acceptance; data holds between writes.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      err_overflow <= 1'b0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) fifo_wr_data <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
      if (fifo_wr_en && fifo_wr_full) err_overflow <= 1'b1;
    end
  end

  // Exact occupancy from beat commits and effective FIFO reads; simultaneous events cancel.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      occupancy <= '0;
    end else begin
      case ({accept, rd_dec})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed testbench for the FIFO write arbiter (default 4 requesters, 256-deep, MAX_PKT_LEN 16).
module tb_sync_fifo_wr_arbiter;

  logic         wr_clk = 1'b0;
  logic         wr_rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         fifo_wr_en;
  logic [31:0]  fifo_wr_data;
  logic         fifo_rd_en;
  logic         fifo_rd_empty;
  logic         fifo_wr_full;
  logic [8:0]   occupancy;
  logic         busy;
  logic [1:0]   grant_id;
  logic         err_oversize;
  logic         err_overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wr_log[$];

  sync_fifo_wr_arbiter dut (
    .wr_clk        (wr_clk),
    .wr_rst        (wr_rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_wr_full  (fifo_wr_full),
    .occupancy     (occupancy),
    .busy          (busy),
    .grant_id      (grant_id),
    .err_oversize  (err_oversize),
    .err_overflow  (err_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  // Record every FIFO write away from the active edge.
  always @(negedge wr_clk) begin
    if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_wr_data);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst        = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    fifo_rd_en    = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_wr_full  = 1'b0;
    tick();
    tick();
    wr_rst = 1'b0;
    wr_log.delete();
  endtask

  // Present one beat and hold it until accepted (bounded); returns with valid dropped.
  task automatic send_beat(input int r, input logic [31:0] d, input logic last, output bit ok);
    ok = 1'b0;
    req_valid[r]        = 1'b1;
    req_last[r]         = last;
    req_data[r*32 +: 32] = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (req_ready[r] === 1'b1) ok = 1'b1;
      tick();
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic send_packet(input int r, input int len, input logic [31:0] base, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int b = 0; b < len; b++) begin
      send_beat(r, base + 32'(b), (b == len - 1), b_ok);
      ok = ok & b_ok;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    n_cmp++; if (occupancy !== 9'd0) begin n_err++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
    n_cmp++; if ({busy, grant_id} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_busy_grant: got %b expected 000", {busy, grant_id}); end
    n_cmp++; if ({err_oversize, err_overflow} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_errs: got %b expected 00", {err_oversize, err_overflow}); end
  endtask

  task automatic test_single_packet();
    bit ok, all_ok;
    do_reset();
    send_beat(0, 32'hA0, 1'b0, ok);
    all_ok = ok;
    n_cmp++; if ({fifo_wr_en, fifo_wr_data} !== {1'b1, 32'hA0}) begin n_err++; $display("[TB] FAIL single_first_write: got %h expected 1000000a0", {fifo_wr_en, fifo_wr_data}); end
    send_beat(0, 32'hA1, 1'b0, ok); all_ok = all_ok & ok;
    send_beat(0, 32'hA2, 1'b0, ok); all_ok = all_ok & ok;
    send_beat(0, 32'hA3, 1'b1, ok); all_ok = all_ok & ok;
    n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("[TB] FAIL single_timeout: got %b expected 1", all_ok); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_busy_after_last: got %b expected 0", busy); end
    n_cmp++; if (occupancy !== 9'd4) begin n_err++; $display("[TB] FAIL single_occ: got %0d expected 4", occupancy); end
    tick();
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL single_wr_en_idle: got %b expected 0", fifo_wr_en); end
    n_cmp++;
    if (wr_log.size() != 4) begin
      n_err++; $display("[TB] FAIL single_log_len: got %0d expected 4", wr_log.size());
    end else if ({wr_log[0], wr_log[1], wr_log[2], wr_log[3]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
      n_err++; $display("[TB] FAIL single_log_data: got %h %h %h %h expected a0 a1 a2 a3", wr_log[0], wr_log[1], wr_log[2], wr_log[3]);
    end
    n_cmp++; if ({err_oversize, err_overflow} !== 2'b00) begin n_err++; $display("[TB] FAIL single_errs: got %b expected 00", {err_oversize, err_overflow}); end
  endtask

  task automatic test_fairness();
    logic [3:0]  acc;
    int          seq[4];
    logic [1:0]  order[$];
    logic        prev_busy;
    logic [63:0] exp_pair;
    int          r_exp;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      seq[r] = 0;
      req_data[r*32 +: 32] = {16'(r), 16'd0};
    end
    req_last  = 4'b0000;
    req_valid = 4'b1111;
    prev_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      acc = req_valid & req_ready;
      if (busy && !prev_busy) order.push_back(grant_id);
      prev_busy = busy;
      tick();
      for (int r = 0; r < 4; r++) begin
        if (acc[r]) begin
          seq[r]++;
          req_last[r] = seq[r][0];
          req_data[r*32 +: 32] = {16'(r), 16'(seq[r])};
        end
      end
    end
    req_valid = '0;
    req_last  = '0;
    tick();
    n_cmp++;
    if (order.size() < 8 || wr_log.size() < 16) begin
      n_err++; $display("[TB] FAIL fair_count: got %0d grants %0d writes expected >=8 >=16", order.size(), wr_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        r_exp = (k + 1) % 4;
        n_cmp++;
        if (order[k] !== 2'(r_exp)) begin
          n_err++; $display("[TB] FAIL fair_grant%0d: got %0d expected %0d", k, order[k], r_exp);
        end
        exp_pair = {16'(r_exp), 16'(2 * (k / 4)), 16'(r_exp), 16'(2 * (k / 4) + 1)};
        n_cmp++;
        if ({wr_log[2*k], wr_log[2*k+1]} !== exp_pair) begin
          n_err++; $display("[TB] FAIL fair_pkt%0d: got %h %h expected %h", k, wr_log[2*k], wr_log[2*k+1], exp_pair);
        end
      end
    end
  endtask

  task automatic test_admission();
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    for (int p = 0; p < 15; p++) begin
      send_packet(0, 16, 32'(p * 16), ok);
      all_ok = all_ok & ok;
    end
    send_packet(0, 1, 32'h0F00, ok);
    all_ok = all_ok & ok;
    n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("[TB] FAIL adm_preload_timeout: got %b expected 1", all_ok); end
    n_cmp++; if ({err_oversize, occupancy} !== {1'b0, 9'd241}) begin n_err++; $display("[TB] FAIL adm_preload_occ: got err %b occ %0d expected err 0 occ 241", err_oversize, occupancy); end
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b1;
    req_data[64 +: 32] = 32'hC2C2;
    tick(); tick(); tick();
    n_cmp++; if ({busy, req_ready} !== 5'b0) begin n_err++; $display("[TB] FAIL adm_no_grant: got %b expected 00000", {busy, req_ready}); end
    fifo_rd_en    = 1'b1;
    fifo_rd_empty = 1'b0;
    tick();
    fifo_rd_en    = 1'b0;
    fifo_rd_empty = 1'b1;
    n_cmp++; if ({busy, occupancy} !== {1'b0, 9'd240}) begin n_err++; $display("[TB] FAIL adm_after_read: got busy %b occ %0d expected busy 0 occ 240", busy, occupancy); end
    tick();
    n_cmp++; if ({busy, grant_id, req_ready} !== {1'b1, 2'd2, 4'b0100}) begin n_err++; $display("[TB] FAIL adm_grant: got %b expected 1100100", {busy, grant_id, req_ready}); end
    tick();
    req_valid = '0;
    req_last  = '0;
    n_cmp++; if ({busy, occupancy} !== {1'b0, 9'd241}) begin n_err++; $display("[TB] FAIL adm_done: got busy %b occ %0d expected busy 0 occ 241", busy, occupancy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid[1] = 1'b1;
    req_data[32 +: 32] = 32'hB0;
    tick();
    tick();
    req_data[32 +: 32] = 32'hB1;
    fifo_rd_en    = 1'b1;
    fifo_rd_empty = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 9'd1) begin n_err++; $display("[TB] FAIL simul_write_read: got %0d expected 1", occupancy); end
    req_data[32 +: 32] = 32'hB2;
    req_last[1]   = 1'b1;
    fifo_rd_empty = 1'b1;
    tick();
    n_cmp++; if (occupancy !== 9'd2) begin n_err++; $display("[TB] FAIL simul_read_empty: got %0d expected 2", occupancy); end
    req_valid     = '0;
    req_last      = '0;
    fifo_rd_empty = 1'b0;
    tick();
    fifo_rd_en    = 1'b0;
    fifo_rd_empty = 1'b1;
    n_cmp++; if ({busy, occupancy} !== {1'b0, 9'd1}) begin n_err++; $display("[TB] FAIL simul_read_only: got busy %b occ %0d expected busy 0 occ 1", busy, occupancy); end
  endtask

  task automatic test_oversize();
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    for (int b = 0; b < 20; b++) begin
      send_beat(0, 32'h500 + 32'(b), (b == 19), ok);
      all_ok = all_ok & ok;
      if (b == 14) begin
        n_cmp++; if (err_oversize !== 1'b0) begin n_err++; $display("[TB] FAIL over_early: got %b expected 0", err_oversize); end
      end
      if (b == 15) begin
        n_cmp++; if (err_oversize !== 1'b1) begin n_err++; $display("[TB] FAIL over_at16: got %b expected 1", err_oversize); end
      end
    end
    tick();
    n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("[TB] FAIL over_timeout: got %b expected 1", all_ok); end
    n_cmp++; if ({wr_log.size() == 20, occupancy} !== {1'b1, 9'd20}) begin n_err++; $display("[TB] FAIL over_written: got %0d writes occ %0d expected 20 20", wr_log.size(), occupancy); end
    for (int b = 0; b < 236; b++) begin
      send_beat(1, 32'h1000 + 32'(b), 1'b0, ok);
      all_ok = all_ok & ok;
    end
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b1;
    req_data[32 +: 32] = 32'h1FFF;
    tick(); tick();
    n_cmp++; if ({all_ok, busy, req_ready, occupancy} !== {1'b1, 1'b1, 4'b0000, 9'd256}) begin n_err++; $display("[TB] FAIL over_full_stall: got ok %b busy %b ready %b occ %0d expected 1 1 0000 256", all_ok, busy, req_ready, occupancy); end
    fifo_rd_en    = 1'b1;
    fifo_rd_empty = 1'b0;
    tick();
    fifo_rd_en    = 1'b0;
    fifo_rd_empty = 1'b1;
    n_cmp++; if ({req_ready, occupancy} !== {4'b0010, 9'd255}) begin n_err++; $display("[TB] FAIL over_resume: got ready %b occ %0d expected 0010 255", req_ready, occupancy); end
    tick();
    req_valid    = '0;
    req_last     = '0;
    fifo_wr_full = 1'b1;
    tick();
    fifo_wr_full = 1'b0;
    n_cmp++; if ({err_overflow, busy, occupancy} !== {1'b1, 1'b0, 9'd256}) begin n_err++; $display("[TB] FAIL over_overflow: got err %b busy %b occ %0d expected 1 0 256", err_overflow, busy, occupancy); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok, all_ok;
    do_reset();
    send_beat(1, 32'hD0, 1'b0, ok); all_ok = ok;
    send_beat(1, 32'hD1, 1'b0, ok); all_ok = all_ok & ok;
    req_valid[1] = 1'b1;
    req_data[32 +: 32] = 32'hD2;
    wr_rst = 1'b1;
    tick();
    n_cmp++; if ({req_ready, fifo_wr_en, busy, occupancy} !== {4'b0, 1'b0, 1'b0, 9'd0}) begin n_err++; $display("[TB] FAIL midrst_state: got ready %b wr_en %b busy %b occ %0d expected 0000 0 0 0", req_ready, fifo_wr_en, busy, occupancy); end
    wr_rst    = 1'b0;
    req_valid = '0;
    req_valid[3] = 1'b1;
    req_data[96 +: 32] = 32'hE0;
    tick();
    n_cmp++; if ({busy, grant_id, req_ready} !== {1'b1, 2'd3, 4'b1000}) begin n_err++; $display("[TB] FAIL midrst_regrant: got %b expected 1111000", {busy, grant_id, req_ready}); end
    send_beat(3, 32'hE0, 1'b0, ok); all_ok = all_ok & ok;
    send_beat(3, 32'hE1, 1'b1, ok); all_ok = all_ok & ok;
    n_cmp++; if ({all_ok, busy, occupancy} !== {1'b1, 1'b0, 9'd2}) begin n_err++; $display("[TB] FAIL midrst_packet: got ok %b busy %b occ %0d expected 1 0 2", all_ok, busy, occupancy); end
  endtask

  initial begin
    wr_rst        = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    fifo_rd_en    = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_wr_full  = 1'b0;
    test_reset();
    test_single_packet();
    test_fairness();
    test_admission();
    test_simultaneous();
    test_oversize();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
